// File: rtl/io_pkg.sv
// io_pkg: shared helpers for the multiplexed debounce scanner.
// Timing math, width helpers, scan states and event field layout.
package io_pkg;

    // Scan sequencer states: wait for the 1 ms tick, then sweep channels.
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    // Event word layout: channel index in the MSBs, new level in bit 0.
    localparam int EVT_LEVEL_BIT = 0;
    localparam int EVT_CHAN_LSB  = 1;

    // Ceiling log2; io_clog2(1) is 0.
    function automatic int io_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Clock cycles in one millisecond.
    function automatic int io_ticks_per_ms(input int freq);
        return freq / 1000;
    endfunction

    // Widths must never collapse to zero bits.
    function automatic int io_max1(input int value);
        return (value < 1) ? 1 : value;
    endfunction

    // Packed event width for a given channel index width.
    function automatic int io_evt_width(input int chan_w);
        return chan_w + 1;
    endfunction

endpackage

// File: rtl/io_event_fifo.sv
// io_event_fifo: show-ahead event queue with full/empty flags.
// A push while full is still taken when a pop happens in the same cycle.
module io_event_fifo
    import io_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = io_max1(io_clog2(DEPTH));

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    // Pointers carry one extra lap bit to tell full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Head word reads zero whenever nothing is queued.
    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Advance read and write pointers on accepted pop/push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage array; when full with a pop, the slot being read is reused.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/io_debounce_scanner.sv
// io_debounce_scanner: one shared 1 ms tick and a scan sequencer that
// debounce every channel in turn and queue each accepted level change.
module io_debounce_scanner
    import io_pkg::*;
#(
    parameter int PARAM_FREQ        = 10000000,
    parameter int PARAM_CHANNELS    = 8,
    parameter int PARAM_DEBOUNCE_MS = 10,
    parameter int PARAM_FIFO_DEPTH  = 4,
    localparam int CHAN_W = io_max1(io_clog2(PARAM_CHANNELS))
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [PARAM_CHANNELS-1:0] i_in,
    output logic [PARAM_CHANNELS-1:0] o_state,
    output logic                      o_evt_valid,
    input  logic                      i_evt_ready,
    output logic [CHAN_W-1:0]         o_evt_chan,
    output logic                      o_evt_level,
    output logic                      o_overflow,
    input  logic                      i_clr_overflow
);

    localparam int TICKS  = io_ticks_per_ms(PARAM_FREQ);
    localparam int TICK_W = io_max1(io_clog2(TICKS));
    localparam int CNT_W  = io_max1(io_clog2(PARAM_DEBOUNCE_MS + 1));
    localparam int EVT_W  = io_evt_width(CHAN_W);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS - 1);
    localparam logic [CHAN_W-1:0] IDX_LAST  = CHAN_W'(PARAM_CHANNELS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PARAM_DEBOUNCE_MS - 1);

    logic [PARAM_CHANNELS-1:0] sync_a;
    logic [PARAM_CHANNELS-1:0] sync_b;
    logic [TICK_W-1:0]         tick_cnt;
    logic                      tick;
    scan_state_t               state;
    logic [CHAN_W-1:0]         idx;
    logic [CNT_W-1:0]          cnt [PARAM_CHANNELS];

    logic                      cur;
    logic                      differs;
    logic                      accept;
    logic [EVT_W-1:0]          evt_word;
    logic [EVT_W-1:0]          head;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      pop;
    logic                      dropped;

    // Two-flop synchronizer per raw input.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= i_in;
            sync_b <= sync_a;
        end
    end

    // Millisecond divider; wraps explicitly at its terminal count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    // Decision for the channel being visited this cycle.
    always_comb begin
        cur      = sync_b[idx];
        differs  = (state == SCAN) && (cur != o_state[idx]);
        accept   = differs && (cnt[idx] == CNT_LAST);
        evt_word = {idx, cur};
    end

    // Scan sequencer with the per-channel persistence counters.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            idx     <= '0;
            o_state <= '0;
            for (int i = 0; i < PARAM_CHANNELS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (tick) begin
                        state <= SCAN;
                        idx   <= '0;
                    end
                end
                SCAN: begin
                    if (!differs) begin
                        cnt[idx] <= '0;
                    end else if (accept) begin
                        cnt[idx]     <= '0;
                        o_state[idx] <= cur;
                    end else begin
                        cnt[idx] <= cnt[idx] + 1'b1;
                    end
                    if (idx == IDX_LAST) begin
                        idx   <= '0;
                        state <= tick ? SCAN : IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign pop     = o_evt_valid && i_evt_ready;
    assign dropped = accept && fifo_full && !pop;

    // Sticky drop flag; a fresh drop beats a clear in the same cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_overflow <= 1'b0;
        end else if (dropped) begin
            o_overflow <= 1'b1;
        end else if (i_clr_overflow) begin
            o_overflow <= 1'b0;
        end
    end

    io_event_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (PARAM_FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (accept),
        .push_data (evt_word),
        .pop       (i_evt_ready),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign o_evt_valid = !fifo_empty;
    assign o_evt_chan  = head[EVT_W-1:EVT_CHAN_LSB];
    assign o_evt_level = head[EVT_LEVEL_BIT];

endmodule

// File: tb/tb_io_debounce_scanner.sv
// tb_io_debounce_scanner: randomized and directed stimulus checked every
// cycle against a millisecond-level reference model with a queue FIFO.
module tb_io_debounce_scanner;
    import io_pkg::*;

    localparam int FREQ  = 8000;
    localparam int N     = 4;
    localparam int DEB   = 3;
    localparam int DEPTH = 2;
    localparam int TPM   = FREQ / 1000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] raw = '1;
    logic [N-1:0] state;
    logic         evt_valid;
    logic         evt_ready = 1'b0;
    logic [1:0]   evt_chan;
    logic         evt_level;
    logic         overflow;
    logic         clr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    int           m_cyc;
    logic [N-1:0] m_state;
    logic [N-1:0] h0;
    logic [N-1:0] h1;
    int           m_run [N];
    logic [2:0]   q [$];
    logic         m_ovf;

    io_debounce_scanner #(
        .PARAM_FREQ        (FREQ),
        .PARAM_CHANNELS    (N),
        .PARAM_DEBOUNCE_MS (DEB),
        .PARAM_FIFO_DEPTH  (DEPTH)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_in           (raw),
        .o_state        (state),
        .o_evt_valid    (evt_valid),
        .i_evt_ready    (evt_ready),
        .o_evt_chan     (evt_chan),
        .o_evt_level    (evt_level),
        .o_overflow     (overflow),
        .i_clr_overflow (clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // A tick must never land in the middle of a sweep.
    always @(negedge clk) begin
        if (!rst && dut.tick && dut.state == SCAN) begin
            check("tick_in_scan", 32'(1), 32'(0));
        end
    end

    task automatic model_reset();
        m_cyc   = 0;
        m_state = '0;
        h0      = '0;
        h1      = '0;
        m_ovf   = 1'b0;
        q.delete();
        for (int i = 0; i < N; i++) m_run[i] = 0;
    endtask

    // Channel scanned during the current cycle, or -1.
    function automatic int visit_chan();
        if (m_cyc >= TPM && (m_cyc % TPM) < N) return m_cyc % TPM;
        return -1;
    endfunction

    // True when the current visit will accept a new level.
    function automatic bit accept_now();
        int ch;
        ch = visit_chan();
        if (ch < 0) return 1'b0;
        return (h1[ch] != m_state[ch]) && (m_run[ch] + 1 == DEB);
    endfunction

    task automatic compare_outputs();
        logic [2:0] hd;
        hd = (q.size() > 0) ? q[0] : 3'b000;
        check("state", 32'(state), 32'(m_state));
        check("valid", 32'(evt_valid), 32'(q.size() > 0));
        check("chan", 32'(evt_chan), 32'(hd[2:1]));
        check("level", 32'(evt_level), 32'(hd[0]));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    // One clock: compare, drive, advance the model across the edge.
    task automatic cycle(input logic [N-1:0] r, input logic rdy,
                         input logic c);
        int   ch;
        bit   ev;
        bit   drop;
        logic lvl;
        compare_outputs();
        raw       = r;
        evt_ready = rdy;
        clr       = c;
        ev   = 1'b0;
        drop = 1'b0;
        lvl  = 1'b0;
        ch   = visit_chan();
        if (ch >= 0) begin
            lvl = h1[ch];
            if (lvl != m_state[ch]) begin
                m_run[ch]++;
                if (m_run[ch] == DEB) begin
                    m_state[ch] = lvl;
                    m_run[ch]   = 0;
                    ev          = 1'b1;
                end
            end else begin
                m_run[ch] = 0;
            end
        end
        if (q.size() > 0 && rdy) void'(q.pop_front());
        if (ev) begin
            if (q.size() < DEPTH) q.push_back({2'(ch), lvl});
            else drop = 1'b1;
        end
        if (drop) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        h1 = h0;
        h0 = r;
        m_cyc++;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset: outputs must clear without waiting for an edge.
    task automatic do_reset(input logic [N-1:0] r);
        rst = 1'b1;
        raw = r;
        #1;
        check("rst_state", 32'(state), 32'(0));
        check("rst_valid", 32'(evt_valid), 32'(0));
        check("rst_chan", 32'(evt_chan), 32'(0));
        check("rst_level", 32'(evt_level), 32'(0));
        check("rst_ovf", 32'(overflow), 32'(0));
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        raw = '0;
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] r;
        bit           seen;

        do_reset(4'hF);
        repeat (200) cycle(4'h0, 1'($urandom % 2), 1'b0);

        repeat (60) cycle(4'b0100, 1'b1, 1'b0);
        check("press_state", 32'(state[2]), 32'(1));
        repeat (60) cycle(4'b0000, 1'b1, 1'b0);
        check("release_state", 32'(state[2]), 32'(0));

        repeat (5) begin
            repeat (16) cycle(4'b0010, 1'b1, 1'b0);
            repeat (8) cycle(4'b0000, 1'b1, 1'b0);
        end
        repeat (40) cycle(4'b0000, 1'b1, 1'b0);
        check("bounce_state", 32'(state[1]), 32'(0));

        repeat (60) cycle(4'b1001, 1'b1, 1'b0);
        check("pair_state", 32'(state), 32'(4'b1001));
        repeat (60) cycle(4'b0000, 1'b1, 1'b0);

        repeat (60) cycle(4'b0111, 1'b0, 1'b0);
        check("ovf_set", 32'(overflow), 32'(1));
        check("ovf_state", 32'(state), 32'(4'b0111));
        cycle(4'b0111, 1'b0, 1'b1);
        check("ovf_clr", 32'(overflow), 32'(0));
        repeat (20) cycle(4'b0111, 1'b1, 1'b0);

        repeat (60) cycle(4'b0100, 1'b0, 1'b0);
        check("full_valid", 32'(evt_valid), 32'(1));
        seen = 1'b0;
        for (int k = 0; k < 80 && !seen; k++) begin
            if (accept_now()) begin
                seen = 1'b1;
                cycle(4'b0000, 1'b1, 1'b0);
            end else begin
                cycle(4'b0000, 1'b0, 1'b0);
            end
        end
        check("pushpop_seen", 32'(seen), 32'(1));
        check("pushpop_ovf", 32'(overflow), 32'(0));
        check("pushpop_valid", 32'(evt_valid), 32'(1));
        repeat (20) cycle(4'b0000, 1'b1, 1'b0);

        r = '0;
        repeat (1500) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom % 24 == 0) r[b] = ~r[b];
            end
            cycle(r, 1'($urandom % 4 != 0), 1'($urandom % 32 == 0));
        end

        repeat (50) cycle(4'b1111, 1'b0, 1'b0);
        for (int k = 0; k < 2 * TPM && visit_chan() != 1; k++) begin
            cycle(4'b1111, 1'b0, 1'b0);
        end
        check("midscan_visit", 32'(visit_chan()), 32'(1));
        do_reset(4'b1111);
        repeat (40) cycle(4'b0000, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
